// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer, in-order single commit per cycle.
// Ports: dispatch alloc/query, NUM_CDB writeback ports, regfile/predictor/LSB commit, rollback.
module rob_param #(
    parameter int ROB_DEPTH = 16,
    parameter int NUM_CDB   = 2,
    parameter int OPTYPE_W  = 6,
    // store optype range, mirrors OPTYPE_SB..OPTYPE_SW in const.v
    parameter int OPTYPE_SB = 22,
    parameter int OPTYPE_SW = 24,
    localparam int IDX_W = $clog2(ROB_DEPTH),
    localparam int TAG_W = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    output logic                    rob_full,
    output logic                    rollback_signal,
    output logic [31:0]             rollback_pc,
    output logic                    ena_pred,
    output logic                    predict_res,
    output logic [31:0]             commit_pc_2pred,
    input  logic                    instr_rdy_from_dsp,
    input  logic [31:0]             pc_from_dsp,
    input  logic [4:0]              instr_rd_from_dsp,
    input  logic                    is_jump_from_dsp,
    input  logic                    jumpRecord_from_dsp,
    input  logic [OPTYPE_W-1:0]     optype_from_dsp,
    output logic [TAG_W-1:0]        renameid_2dsp,
    input  logic [TAG_W-1:0]        Qi_query_from_dsp,
    input  logic [TAG_W-1:0]        Qj_query_from_dsp,
    output logic                    rob_Qi_rdy,
    output logic                    rob_Qj_rdy,
    output logic [31:0]             Vi_2dsp,
    output logic [31:0]             Vj_2dsp,
    input  logic [NUM_CDB-1:0]      cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*32-1:0]   cdb_val,
    input  logic [NUM_CDB-1:0]      cdb_jump_res,
    input  logic [NUM_CDB*32-1:0]   cdb_jump_pc,
    output logic                    store_prepared_to_commit,
    output logic                    store_commit,
    output logic                    res_rdy_2reg,
    output logic [31:0]             res_2reg,
    output logic [4:0]              regidx_2regfile,
    output logic [TAG_W-1:0]        reg_alias
);

    logic [IDX_W-1:0]    head, tail;
    logic [TAG_W-1:0]    count;
    logic [ROB_DEPTH-1:0] ready, is_jump, jump_record, jump_result;
    logic [OPTYPE_W-1:0] optype [ROB_DEPTH];
    logic [31:0]         pc [ROB_DEPTH];
    logic [31:0]         val [ROB_DEPTH];
    logic [31:0]         jump_taken_pc [ROB_DEPTH];
    logic [4:0]          rd [ROB_DEPTH];

    logic                do_commit, do_alloc;
    logic [NUM_CDB-1:0]  wb_en;
    logic [IDX_W-1:0]    wb_idx [NUM_CDB];

    function automatic logic is_store(input logic [OPTYPE_W-1:0] op);
        return (op >= OPTYPE_W'(OPTYPE_SB)) && (op <= OPTYPE_W'(OPTYPE_SW));
    endfunction

    // {ready, value}; later CDB ports override earlier ones and the stored copy
    function automatic logic [32:0] lookup(input logic [TAG_W-1:0] q);
        logic [32:0] r;
        r = '0;
        if (q != '0) begin
            r = {ready[IDX_W'(q - TAG_W'(1))], val[IDX_W'(q - TAG_W'(1))]};
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q)
                    r = {1'b1, cdb_val[k*32 +: 32]};
            end
        end
        return r;
    endfunction

    assign {rob_Qi_rdy, Vi_2dsp} = lookup(Qi_query_from_dsp);
    assign {rob_Qj_rdy, Vj_2dsp} = lookup(Qj_query_from_dsp);

    assign rob_full      = (count == TAG_W'(ROB_DEPTH));
    assign renameid_2dsp = {1'b0, tail} + TAG_W'(1);
    assign store_prepared_to_commit = (count != '0) && is_store(optype[head]);
    assign do_commit     = (count != '0) && ready[head];
    assign do_alloc      = instr_rdy_from_dsp && !rob_full;

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            wb_en[k]  = cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] != '0);
            wb_idx[k] = IDX_W'(cdb_tag[k*TAG_W +: TAG_W] - TAG_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ready           <= '0;
            rollback_signal <= 1'b0;
            rollback_pc     <= '0;
            ena_pred        <= 1'b0;
            predict_res     <= 1'b0;
            commit_pc_2pred <= '0;
            store_commit    <= 1'b0;
            res_rdy_2reg    <= 1'b0;
            res_2reg        <= '0;
            regidx_2regfile <= '0;
            reg_alias       <= '0;
        end else if (rollback_signal) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ready           <= '0;
            rollback_signal <= 1'b0;
            ena_pred        <= 1'b0;
            store_commit    <= 1'b0;
            res_rdy_2reg    <= 1'b0;
        end else if (rdy) begin
            ena_pred     <= 1'b0;
            store_commit <= 1'b0;
            res_rdy_2reg <= 1'b0;
            if (do_commit) begin
                ready[head] <= 1'b0;
                head        <= head + IDX_W'(1);
                if (rd[head] != 5'd0) begin
                    res_rdy_2reg    <= 1'b1;
                    res_2reg        <= val[head];
                    regidx_2regfile <= rd[head];
                    reg_alias       <= {1'b0, head} + TAG_W'(1);
                end
                if (is_store(optype[head]))
                    store_commit <= 1'b1;
                if (is_jump[head]) begin
                    ena_pred        <= 1'b1;
                    commit_pc_2pred <= pc[head];
                    predict_res     <= (jump_record[head] == jump_result[head]);
                    if (jump_record[head] != jump_result[head]) begin
                        rollback_signal <= 1'b1;
                        rollback_pc     <= jump_result[head] ? jump_taken_pc[head]
                                                             : pc[head] + 32'd4;
                    end
                end
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                if (wb_en[k]) begin
                    ready[wb_idx[k]]         <= 1'b1;
                    val[wb_idx[k]]           <= cdb_val[k*32 +: 32];
                    jump_result[wb_idx[k]]   <= cdb_jump_res[k];
                    jump_taken_pc[wb_idx[k]] <= cdb_jump_pc[k*32 +: 32];
                end
            end
            if (do_alloc) begin
                ready[tail]       <= 1'b0;
                is_jump[tail]     <= is_jump_from_dsp;
                jump_record[tail] <= jumpRecord_from_dsp;
                optype[tail]      <= optype_from_dsp;
                pc[tail]          <= pc_from_dsp;
                rd[tail]          <= instr_rd_from_dsp;
                tail              <= tail + IDX_W'(1);
            end
            if (do_alloc && !do_commit)
                count <= count + TAG_W'(1);
            else if (!do_alloc && do_commit)
                count <= count - TAG_W'(1);
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed bench for rob_param with a commit scoreboard.
// Ports: none; drives every DUT port and prints a pass summary.
module tb_rob_param;
    localparam int TW = 5;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_BR  = 6'd2;
    localparam logic [5:0] OP_SW  = 6'd24;

    logic        clk, rst, rdy;
    logic        rob_full, rollback_signal, ena_pred, predict_res;
    logic [31:0] rollback_pc, commit_pc_2pred;
    logic        instr_rdy_from_dsp, is_jump_from_dsp, jumpRecord_from_dsp;
    logic [31:0] pc_from_dsp;
    logic [4:0]  instr_rd_from_dsp;
    logic [5:0]  optype_from_dsp;
    logic [TW-1:0] renameid_2dsp, Qi_query_from_dsp, Qj_query_from_dsp;
    logic        rob_Qi_rdy, rob_Qj_rdy;
    logic [31:0] Vi_2dsp, Vj_2dsp;
    logic [1:0]  cdb_valid, cdb_jump_res;
    logic [2*TW-1:0] cdb_tag;
    logic [63:0] cdb_val, cdb_jump_pc;
    logic        store_prepared_to_commit, store_commit, res_rdy_2reg;
    logic [31:0] res_2reg;
    logic [4:0]  regidx_2regfile;
    logic [TW-1:0] reg_alias;

    typedef struct {
        logic [4:0]    rd;
        logic [31:0]   val;
        logic [TW-1:0] tag;
        logic          st;
    } exp_t;

    exp_t sb[$];
    int passed = 0;
    int total  = 0;

    rob_param #(
        .ROB_DEPTH(16), .NUM_CDB(2), .OPTYPE_W(6),
        .OPTYPE_SB(22), .OPTYPE_SW(24)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rob_full(rob_full),
        .rollback_signal(rollback_signal), .rollback_pc(rollback_pc),
        .ena_pred(ena_pred), .predict_res(predict_res),
        .commit_pc_2pred(commit_pc_2pred),
        .instr_rdy_from_dsp(instr_rdy_from_dsp), .pc_from_dsp(pc_from_dsp),
        .instr_rd_from_dsp(instr_rd_from_dsp), .is_jump_from_dsp(is_jump_from_dsp),
        .jumpRecord_from_dsp(jumpRecord_from_dsp), .optype_from_dsp(optype_from_dsp),
        .renameid_2dsp(renameid_2dsp),
        .Qi_query_from_dsp(Qi_query_from_dsp), .Qj_query_from_dsp(Qj_query_from_dsp),
        .rob_Qi_rdy(rob_Qi_rdy), .rob_Qj_rdy(rob_Qj_rdy),
        .Vi_2dsp(Vi_2dsp), .Vj_2dsp(Vj_2dsp),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .cdb_jump_res(cdb_jump_res), .cdb_jump_pc(cdb_jump_pc),
        .store_prepared_to_commit(store_prepared_to_commit),
        .store_commit(store_commit),
        .res_rdy_2reg(res_rdy_2reg), .res_2reg(res_2reg),
        .regidx_2regfile(regidx_2regfile), .reg_alias(reg_alias)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] v,
                        input logic [TW-1:0] tag, input logic st);
        exp_t e;
        e.rd = rd; e.val = v; e.tag = tag; e.st = st;
        sb.push_back(e);
    endtask

    // advance one clock; any commit pulse is matched against the scoreboard head
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (res_rdy_2reg || store_commit) begin
            if (sb.size() == 0) begin
                check("extra_commit", {31'b0, res_rdy_2reg | store_commit}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("commit_store", {31'b0, store_commit}, {31'b0, e.st});
                check("commit_wr", {31'b0, res_rdy_2reg}, {31'b0, e.rd != 5'd0});
                if (e.rd != 5'd0) begin
                    check("commit_val", res_2reg, e.val);
                    check("commit_rd", {27'b0, regidx_2regfile}, {27'b0, e.rd});
                    check("commit_alias", {27'b0, reg_alias}, {27'b0, e.tag});
                end
            end
        end
    endtask

    task automatic clear_cdb();
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
        cdb_jump_res = '0; cdb_jump_pc = '0;
    endtask

    task automatic set_cdb(input int p, input logic [TW-1:0] tag, input logic [31:0] v,
                           input logic jr, input logic [31:0] jpc);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*TW +: TW] = tag;
        cdb_val[p*32 +: 32] = v;
        cdb_jump_res[p] = jr;
        cdb_jump_pc[p*32 +: 32] = jpc;
    endtask

    task automatic set_dsp(input logic [31:0] pc, input logic [4:0] rd,
                           input logic jmp, input logic rec, input logic [5:0] op);
        instr_rdy_from_dsp = 1'b1;
        pc_from_dsp = pc; instr_rd_from_dsp = rd;
        is_jump_from_dsp = jmp; jumpRecord_from_dsp = rec; optype_from_dsp = op;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [4:0] rd,
                         input logic jmp, input logic rec, input logic [5:0] op);
        set_dsp(pc, rd, jmp, rec, op);
        tick();
        instr_rdy_from_dsp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        instr_rdy_from_dsp = 1'b0; pc_from_dsp = '0; instr_rd_from_dsp = '0;
        is_jump_from_dsp = 1'b0; jumpRecord_from_dsp = 1'b0; optype_from_dsp = '0;
        Qi_query_from_dsp = '0; Qj_query_from_dsp = '0;
        clear_cdb();

        // reset state
        do_reset();
        check("rst_full", {31'b0, rob_full}, 32'd0);
        check("rst_tag", {27'b0, renameid_2dsp}, 32'd1);
        check("rst_rollback", {31'b0, rollback_signal}, 32'd0);
        check("rst_pred", {31'b0, ena_pred}, 32'd0);
        check("rst_res_rdy", {31'b0, res_rdy_2reg}, 32'd0);
        check("rst_store", {31'b0, store_commit}, 32'd0);
        check("rst_res", res_2reg, 32'd0);
        check("rst_alias", {27'b0, reg_alias}, 32'd0);
        check("rst_rbpc", rollback_pc, 32'd0);

        // fill all 16 slots, then a 17th request is ignored
        for (int i = 0; i < 16; i++) begin
            set_dsp(32'(i * 4), 5'(i + 1), 1'b0, 1'b0, OP_ADD);
            #1;
            check("fill_tag", {27'b0, renameid_2dsp}, 32'(i + 1));
            if (i == 15) check("fill_not_full", {31'b0, rob_full}, 32'd0);
            tick();
        end
        check("fill_full", {31'b0, rob_full}, 32'd1);
        check("fill_wrap_tag", {27'b0, renameid_2dsp}, 32'd1);
        tick();
        instr_rdy_from_dsp = 1'b0;
        check("over_full", {31'b0, rob_full}, 32'd1);
        check("over_tag", {27'b0, renameid_2dsp}, 32'd1);

        // bypass and in-order commit
        do_reset();
        alloc(32'h0, 5'd1, 1'b0, 1'b0, OP_ADD); push(5'd1, 32'h11, 5'd1, 1'b0);
        alloc(32'h4, 5'd2, 1'b0, 1'b0, OP_ADD); push(5'd2, 32'h22, 5'd2, 1'b0);
        alloc(32'h8, 5'd5, 1'b0, 1'b0, OP_ADD); push(5'd5, 32'hDEADBEEF, 5'd3, 1'b0);
        set_cdb(1, 5'd3, 32'hDEADBEEF, 1'b0, 32'h0);
        Qi_query_from_dsp = 5'd3; Qj_query_from_dsp = 5'd2;
        #1;
        check("byp_qi_rdy", {31'b0, rob_Qi_rdy}, 32'd1);
        check("byp_vi", Vi_2dsp, 32'hDEADBEEF);
        check("byp_qj_rdy", {31'b0, rob_Qj_rdy}, 32'd0);
        tick();
        clear_cdb();
        Qj_query_from_dsp = '0;
        #1;
        check("stored_qi_rdy", {31'b0, rob_Qi_rdy}, 32'd1);
        check("stored_vi", Vi_2dsp, 32'hDEADBEEF);
        Qi_query_from_dsp = '0;
        #1;
        check("q0_rdy", {31'b0, rob_Qi_rdy}, 32'd0);
        check("q0_v", Vi_2dsp, 32'd0);
        set_cdb(0, 5'd1, 32'h11, 1'b0, 32'h0);
        set_cdb(1, 5'd2, 32'h22, 1'b0, 32'h0);
        tick();
        clear_cdb();
        repeat (4) tick();
        check("byp_drained", 32'(sb.size()), 32'd0);
        check("byp_tag", {27'b0, renameid_2dsp}, 32'd4);

        // mispredicted branch: predicted taken, resolves not taken
        do_reset();
        alloc(32'h100, 5'd0, 1'b1, 1'b1, OP_BR);
        alloc(32'h104, 5'd7, 1'b0, 1'b0, OP_ADD);
        set_cdb(0, 5'd1, 32'h0, 1'b0, 32'h200);
        tick();
        clear_cdb();
        tick();
        check("br_ena", {31'b0, ena_pred}, 32'd1);
        check("br_pres", {31'b0, predict_res}, 32'd0);
        check("br_pc", commit_pc_2pred, 32'h100);
        check("br_rb", {31'b0, rollback_signal}, 32'd1);
        check("br_rbpc", rollback_pc, 32'h104);
        set_cdb(0, 5'd2, 32'h77, 1'b0, 32'h0);
        set_dsp(32'h108, 5'd8, 1'b0, 1'b0, OP_ADD);
        tick();
        clear_cdb();
        instr_rdy_from_dsp = 1'b0;
        check("fl_rb", {31'b0, rollback_signal}, 32'd0);
        check("fl_ena", {31'b0, ena_pred}, 32'd0);
        check("fl_tag", {27'b0, renameid_2dsp}, 32'd1);
        check("fl_full", {31'b0, rob_full}, 32'd0);
        Qi_query_from_dsp = 5'd2;
        #1;
        check("fl_qi_rdy", {31'b0, rob_Qi_rdy}, 32'd0);
        Qi_query_from_dsp = '0;
        repeat (3) tick();
        check("fl_empty_tag", {27'b0, renameid_2dsp}, 32'd1);

        // store at head
        do_reset();
        alloc(32'h200, 5'd0, 1'b0, 1'b0, OP_SW); push(5'd0, 32'h0, 5'd1, 1'b1);
        check("st_prep", {31'b0, store_prepared_to_commit}, 32'd1);
        set_cdb(0, 5'd1, 32'h0, 1'b0, 32'h0);
        tick();
        clear_cdb();
        check("st_prep_wb", {31'b0, store_prepared_to_commit}, 32'd1);
        tick();
        check("st_done", 32'(sb.size()), 32'd0);
        check("st_prep_after", {31'b0, store_prepared_to_commit}, 32'd0);
        tick();
        check("st_pulse_end", {31'b0, store_commit}, 32'd0);

        // wrap-around with three in flight
        do_reset();
        for (int c = 0; c < 44; c++) begin
            if (c < 40) begin
                set_dsp(32'(c * 4), 5'((c % 31) + 1), 1'b0, 1'b0, OP_ADD);
                #1;
                check("wrap_tag", {27'b0, renameid_2dsp}, 32'((c % 16) + 1));
                push(5'((c % 31) + 1), 32'hA000 + 32'(c), 5'((c % 16) + 1), 1'b0);
            end else begin
                instr_rdy_from_dsp = 1'b0;
            end
            if (c >= 2 && c - 2 < 40)
                set_cdb(c % 2, 5'(((c - 2) % 16) + 1), 32'hA000 + 32'(c - 2), 1'b0, 32'h0);
            tick();
            clear_cdb();
            check("wrap_nfull", {31'b0, rob_full}, 32'd0);
            check("wrap_inflight", {31'b0, sb.size() <= 3}, 32'd1);
        end
        instr_rdy_from_dsp = 1'b0;
        repeat (2) tick();
        check("wrap_drained", 32'(sb.size()), 32'd0);

        // rdy stall right before a commit
        do_reset();
        alloc(32'h0, 5'd9, 1'b0, 1'b0, OP_ADD);  push(5'd9, 32'h99, 5'd1, 1'b0);
        alloc(32'h4, 5'd10, 1'b0, 1'b0, OP_ADD); push(5'd10, 32'h1010, 5'd2, 1'b0);
        set_cdb(0, 5'd1, 32'h99, 1'b0, 32'h0);
        tick();
        clear_cdb();
        rdy = 1'b0;
        set_dsp(32'h8, 5'd11, 1'b0, 1'b0, OP_ADD);
        set_cdb(1, 5'd2, 32'h1010, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_res", {31'b0, res_rdy_2reg}, 32'd0);
            check("stall_tag", {27'b0, renameid_2dsp}, 32'd3);
            check("stall_sb", 32'(sb.size()), 32'd2);
        end
        rdy = 1'b1;
        instr_rdy_from_dsp = 1'b0;
        clear_cdb();
        tick();
        check("resume_commit", 32'(sb.size()), 32'd1);
        tick();
        check("resume_hold", 32'(sb.size()), 32'd1);
        set_cdb(0, 5'd2, 32'h1010, 1'b0, 32'h0);
        tick();
        clear_cdb();
        tick();
        check("resume_done", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
